// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
package div_issue_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    DIV_CTRL_IDLE   = 2'd0,
    DIV_CTRL_BUSY   = 2'd1,
    DIV_CTRL_DONE   = 2'd2,
    DIV_CTRL_CANCEL = 2'd3
  } div_ctrl_state_e;

  // Start line levels seen by the divider
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // Width of a counter that must hold values 0..n (at least one bit)
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: latches operands, runs the
// start/annul handshake, stalls EX until the result returns and presents HI/LO.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int CANCEL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_req_i,
  input  logic                div_signed_i,
  input  logic [DATA_W-1:0]   reg1_i,
  input  logic [DATA_W-1:0]   reg2_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_op1_o,
  output logic [DATA_W-1:0]   div_op2_o,
  output logic                stallreq_o,
  output logic                whilo_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  localparam int            CW          = cnt_width(CANCEL_CYCLES);
  localparam logic [CW-1:0] CANCEL_LAST = CW'(CANCEL_CYCLES - 1);

  div_ctrl_state_e state;
  logic [CW-1:0]   cancel_cnt;

  // Handshake FSM; every output toward div and the HI/LO pair are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DIV_CTRL_IDLE;
      cancel_cnt   <= '0;
      div_start_o  <= DIV_STOP;
      div_annul_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else begin
      case (state)
        DIV_CTRL_IDLE: begin
          if (div_req_i && !flush_i) begin
            div_signed_o <= div_signed_i;
            div_op1_o    <= reg1_i;
            div_op2_o    <= reg2_i;
            div_start_o  <= DIV_START;
            state        <= DIV_CTRL_BUSY;
          end
        end
        DIV_CTRL_BUSY: begin
          // Operands stay frozen: div re-reads the dividend sign when it finishes.
          // Flush wins over a same-cycle ready so a killed divide never writes HI/LO.
          if (flush_i) begin
            div_start_o <= DIV_STOP;
            div_annul_o <= 1'b1;
            cancel_cnt  <= '0;
            state       <= DIV_CTRL_CANCEL;
          end else if (div_ready_i) begin
            hi_o        <= div_result_i[2*DATA_W-1:DATA_W];
            lo_o        <= div_result_i[DATA_W-1:0];
            div_start_o <= DIV_STOP;
            state       <= DIV_CTRL_DONE;
          end
        end
        DIV_CTRL_DONE: begin
          // A held EX stays here; no re-issue until the pipeline moves on
          if (flush_i || !stall_i) state <= DIV_CTRL_IDLE;
        end
        DIV_CTRL_CANCEL: begin
          // Hold annul long enough for div to fall back to its free state
          if (cancel_cnt == CANCEL_LAST) begin
            div_annul_o <= 1'b0;
            cancel_cnt  <= '0;
            state       <= DIV_CTRL_IDLE;
          end else begin
            cancel_cnt <= cancel_cnt + 1'b1;
          end
        end
        default: state <= DIV_CTRL_IDLE;
      endcase
    end
  end

  // Stall request and HI/LO write enable follow the current state combinationally
  always_comb begin
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    case (state)
      DIV_CTRL_IDLE:   stallreq_o = div_req_i && !flush_i;
      DIV_CTRL_BUSY:   stallreq_o = 1'b1;
      DIV_CTRL_DONE:   whilo_o    = !stall_i && !flush_i;
      DIV_CTRL_CANCEL: stallreq_o = div_req_i;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a behavioural divider answers the handshake,
// table vectors cover the arithmetic cases, hand sequences cover flush/stall/reset.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req, div_sgn, stall, flush;
  logic [31:0] reg1, reg2;
  logic [63:0] div_result;
  logic        div_ready;
  logic        div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o;
  logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DATA_W(32), .CANCEL_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .div_req_i(div_req), .div_signed_i(div_sgn),
    .reg1_i(reg1), .reg2_i(reg2),
    .stall_i(stall), .flush_i(flush),
    .div_result_i(div_result), .div_ready_i(div_ready),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .stallreq_o(stallreq_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  // Behavioural divider: {rem, quo}, 35 cycles (3 for a zero divisor) of start
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  int m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; div_ready <= 1'b0; div_result <= 64'd0;
    end else if (!div_start_o || div_annul_o) begin
      m_cnt <= 0; div_ready <= 1'b0; div_result <= 64'd0;
    end else begin
      m_cnt      <= m_cnt + 1;
      div_ready  <= (m_cnt == ((div_op2_o == 32'd0) ? 3 : 35) - 1);
      div_result <= ref_div(div_signed_o, div_op1_o, div_op2_o);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the HI/LO write; stallreq and frozen operands are tracked meanwhile
  task automatic wait_whilo(output int cyc, output logic got, output logic [31:0] hi, output logic [31:0] lo,
                            output int bad);
    cyc = 0; got = 1'b0; hi = 32'd0; lo = 32'd0; bad = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (whilo_o) begin
        got = 1'b1; hi = hi_o; lo = lo_o;
      end else begin
        if (!stallreq_o) bad++;
        if (div_start_o && (div_op1_o !== reg1 || div_op2_o !== reg2 || div_signed_o !== div_sgn)) bad++;
      end
    end
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic [31:0] hi, output logic [31:0] lo);
    logic got;
    int   bad;
    @(negedge clk);
    div_req = 1'b1; div_sgn = s; reg1 = a; reg2 = b;
    #1 chk("req_stallreq", stallreq_o, 1);
    wait_whilo(cyc, got, hi, lo, bad);
    chk("whilo_seen", got, 1);
    chk("busy_stall_ops", bad, 0);
    chk("done_start_low", div_start_o, 0);
    chk("done_stallreq_low", stallreq_o, 0);
    @(negedge clk);
    div_req = 1'b0;
    @(posedge clk); #1;
    chk("whilo_one_cycle", whilo_o, 0);
    chk("no_restart", div_start_o, 0);
  endtask

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          cyc, bad;
    logic        got;
    logic [31:0] hi, lo;

    vecs[0] = '{"divu_100_7",  1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         37};
    vecs[1] = '{"div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  37};
    vecs[2] = '{"div_5_0",     1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          5};
    vecs[3] = '{"divu_9_3",    1'b0, 32'd9,          32'd3,          32'd0,          32'd3,          37};
    vecs[4] = '{"divu_max_16", 1'b0, 32'hFFFF_FFFF,  32'd16,         32'd15,         32'h0FFF_FFFF,  37};
    vecs[5] = '{"div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  37};
    vecs[6] = '{"div_m8_m3",   1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  32'd2,          37};

    rst = 1'b1; div_req = 0; div_sgn = 0; stall = 0; flush = 0; reg1 = 0; reg2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", div_start_o, 0);
    chk("rst_annul", div_annul_o, 0);
    chk("rst_ops",   {div_op1_o, div_op2_o}, 0);
    chk("rst_hilo",  {hi_o, lo_o}, 0);
    chk("rst_stall_whilo", {stallreq_o, whilo_o}, 0);
    @(negedge clk); rst = 1'b0;

    // Table-driven arithmetic and latency
    foreach (vecs[i]) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, cyc, hi, lo);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
      chk({vecs[i].name, "_cyc"}, cyc, vecs[i].cyc);
    end

    // Flush in BUSY: annul for two cycles, no write, queued divide then runs
    @(negedge clk);
    div_req = 1'b1; div_sgn = 1'b0; reg1 = 32'd100; reg2 = 32'd7;
    repeat (10) @(posedge clk);
    #1 chk("flush_pre_busy", {div_start_o, stallreq_o}, 2'b11);
    @(negedge clk); flush = 1'b1; div_req = 1'b0;
    @(posedge clk); #1;
    chk("cancel1_annul_start", {div_annul_o, div_start_o}, 2'b10);
    chk("cancel1_whilo", whilo_o, 0);
    @(negedge clk); flush = 1'b0; div_req = 1'b1; reg1 = 32'd9; reg2 = 32'd3;
    #1 chk("cancel_waits_stallreq", stallreq_o, 1);
    @(posedge clk); #1;
    chk("cancel2_annul_start", {div_annul_o, div_start_o}, 2'b10);
    chk("cancel2_whilo", whilo_o, 0);
    @(posedge clk); #1;
    chk("cancel_end_annul_start", {div_annul_o, div_start_o}, 2'b00);
    wait_whilo(cyc, got, hi, lo, bad);
    chk("after_flush_seen", got, 1);
    chk("after_flush_hilo", {hi, lo}, {32'd0, 32'd3});
    chk("after_flush_busy", bad, 0);
    @(negedge clk); div_req = 1'b0;
    @(posedge clk); #1;

    // Stall held across DONE: no write and no re-issue until released
    @(negedge clk);
    div_req = 1'b1; div_sgn = 1'b0; reg1 = 32'd100; reg2 = 32'd7; stall = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (stallreq_o && cyc < 200);
    chk("stall_done_reached", cyc < 200, 1);
    chk("stall_done_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk("stall_whilo_held", whilo_o, 0);
      chk("stall_no_restart", {div_start_o, stallreq_o}, 2'b00);
    end
    @(negedge clk); stall = 1'b0; div_req = 1'b0;
    #1 chk("stall_release_whilo", whilo_o, 1);
    @(posedge clk); #1;
    chk("stall_whilo_once", whilo_o, 0);
    chk("stall_release_no_start", div_start_o, 0);

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    div_req = 1'b1; div_sgn = 1'b1; reg1 = 32'hFFFF_FFF9; reg2 = 32'd2;
    repeat (5) @(posedge clk);
    @(negedge clk); div_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_start_annul", {div_start_o, div_annul_o, div_signed_o}, 0);
    chk("arst_ops",  {div_op1_o, div_op2_o}, 0);
    chk("arst_hilo", {hi_o, lo_o}, 0);
    chk("arst_comb", {stallreq_o, whilo_o}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {div_start_o, stallreq_o, whilo_o}, 0);
    run_div(1'b0, 32'd9, 32'd3, cyc, hi, lo);
    chk("post_rst_hilo", {hi, lo}, {32'd0, 32'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
